// File: rtl/calc_pkg.sv
// Shared types and constants for the keypad calculator sequencer.
// Holds state encoding, key codes and operand width.
package calc_pkg;

  localparam int OPW = 8;

  typedef enum logic [2:0] {
    ST_ENTRY_A,
    ST_LOAD_A,
    ST_ENTRY_B,
    ST_LOAD_B,
    ST_LOAD_R,
    ST_SHOW
  } state_t;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_CLR = 4'hC;
  localparam logic [3:0] KEY_EQ  = 4'hE;

  function automatic logic is_digit(
    input logic [3:0] k
  );
    return k <= 4'd9;
  endfunction

  function automatic logic is_op(
    input logic [3:0] k
  );
    return (k == KEY_ADD) || (k == KEY_SUB);
  endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Keypad/arithmetic-unit bundle for the calculator sequencer.
// master drives keys and result; slave is the sequencer.
interface calc_sequencer_if;
  import calc_pkg::*;

  logic           key_valid;
  logic [3:0]     key_code;
  logic [OPW-1:0] result;
  logic [OPW-1:0] operand;
  logic           LoadA;
  logic           LoadB;
  logic           LoadR;
  logic           Cin;
  logic           disp_sel;
  logic           clear;
  logic           busy;

  modport master (
    output key_valid,
    output key_code,
    output result,
    input  operand,
    input  LoadA,
    input  LoadB,
    input  LoadR,
    input  Cin,
    input  disp_sel,
    input  clear,
    input  busy
  );

  modport slave (
    input  key_valid,
    input  key_code,
    input  result,
    output operand,
    output LoadA,
    output LoadB,
    output LoadR,
    output Cin,
    output disp_sel,
    output clear,
    output busy
  );

endinterface

// File: rtl/dec_accum.sv
// Decimal digit accumulator: cur*10+digit with an upper bound.
// accept drops when the new value would exceed OPERAND_MAX.
module dec_accum
  import calc_pkg::*;
#(
  parameter int OPERAND_MAX = 255
) (
  input  logic [OPW-1:0] cur,
  input  logic [3:0]     digit,
  output logic [OPW-1:0] next_val,
  output logic           accept
);

  logic [11:0] sum;

  // 255*10+9 = 2559 still fits in 12 bits
  assign sum      = ({4'b0, cur} * 12'd10) + {8'b0, digit};
  assign accept   = sum <= 12'(OPERAND_MAX);
  assign next_val = sum[OPW-1:0];

endmodule

// File: rtl/calc_sequencer.sv
// Keypad-driven load sequencer for a two-operand add/sub unit.
// All outputs come from flops; keys never reach outputs combinationally.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int OPERAND_MAX = 255
) (
  input logic clock,
  input logic reset,
  calc_sequencer_if.slave bus
);

  state_t         state_q, state_d;
  logic [OPW-1:0] operand_q, operand_d;
  logic           cin_q, cin_d;
  logic           clear_q, clear_d;
  logic           load_a_q, load_a_d;
  logic           load_b_q, load_b_d;
  logic           load_r_q, load_r_d;
  logic           busy_q, busy_d;
  logic           disp_q, disp_d;

  logic [OPW-1:0] acc_val;
  logic           acc_ok;
  logic           key_ok;
  logic           k_dig;
  logic           k_op;
  logic           k_clr;
  logic           k_eq;

  dec_accum #(
    .OPERAND_MAX (OPERAND_MAX)
  ) u_acc (
    .cur      (operand_q),
    .digit    (bus.key_code),
    .next_val (acc_val),
    .accept   (acc_ok)
  );

  assign key_ok = bus.key_valid && !busy_q;
  assign k_dig  = key_ok && is_digit(bus.key_code);
  assign k_op   = key_ok && is_op(bus.key_code);
  assign k_clr  = key_ok && (bus.key_code == KEY_CLR);
  assign k_eq   = key_ok && (bus.key_code == KEY_EQ);

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    cin_d     = cin_q;
    clear_d   = 1'b0;
    unique case (state_q)
      ST_LOAD_A: begin
        state_d   = ST_ENTRY_B;
        operand_d = '0;
      end
      ST_LOAD_B: state_d = ST_LOAD_R;
      ST_LOAD_R: state_d = ST_SHOW;
      default: begin
        unique case (1'b1)
          k_clr: begin
            state_d   = ST_ENTRY_A;
            operand_d = '0;
            cin_d     = 1'b0;
            clear_d   = 1'b1;
          end
          k_dig: begin
            if (state_q == ST_SHOW) begin
              state_d   = ST_ENTRY_A;
              operand_d = OPW'(bus.key_code);
            end else if (acc_ok) begin
              operand_d = acc_val;
            end
          end
          k_op: begin
            cin_d = bus.key_code == KEY_SUB;
            // in ENTRY_B an operator only swaps the op
            if (state_q != ST_ENTRY_B)
              state_d = ST_LOAD_A;
            if (state_q == ST_SHOW)
              operand_d = bus.result;
          end
          k_eq: begin
            if (state_q == ST_ENTRY_B)
              state_d = ST_LOAD_B;
          end
          default: ;
        endcase
      end
    endcase
  end

  always_comb begin
    load_a_d = state_d == ST_LOAD_A;
    load_b_d = state_d == ST_LOAD_B;
    load_r_d = state_d == ST_LOAD_R;
    busy_d   = load_a_d || load_b_d || load_r_d;
    disp_d   = state_d == ST_SHOW;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_ENTRY_A;
      operand_q <= '0;
      cin_q     <= 1'b0;
      clear_q   <= 1'b0;
      load_a_q  <= 1'b0;
      load_b_q  <= 1'b0;
      load_r_q  <= 1'b0;
      busy_q    <= 1'b0;
      disp_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      cin_q     <= cin_d;
      clear_q   <= clear_d;
      load_a_q  <= load_a_d;
      load_b_q  <= load_b_d;
      load_r_q  <= load_r_d;
      busy_q    <= busy_d;
      disp_q    <= disp_d;
    end
  end

  assign bus.operand  = operand_q;
  assign bus.Cin      = cin_q;
  assign bus.clear    = clear_q;
  assign bus.LoadA    = load_a_q;
  assign bus.LoadB    = load_b_q;
  assign bus.LoadR    = load_r_q;
  assign bus.busy     = busy_q;
  assign bus.disp_sel = disp_q;

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter OPERAND_MAX, default 255, SHALL be the largest operand value accepted from the keypad (range 9..255).
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; SHALL force the reset state immediately.
REQ-004 key_valid  input  1  one-cycle strobe from the keypad scanner marking a new key.
REQ-005 key_code  input  4  key code: 0x0-0x9 digit, 0xA add, 0xB subtract, 0xC clear, 0xE equals; 0xD and 0xF are unused.
REQ-006 result  input  8  arithmetic-unit result register, read only in SHOW.
REQ-007 operand  output  8  registered operand bus to the arithmetic-unit A/B inputs and the display mux.
REQ-008 LoadA, LoadB, LoadR  output  1 each  one-cycle load strobes to the arithmetic unit.
REQ-009 Cin  output  1  operation select: 0 = add, 1 = subtract; registered.
REQ-010 disp_sel  output  1  display mux select: 0 = operand, 1 = result.
REQ-011 clear  output  1  one-cycle clear strobe.
REQ-012 busy  output  1  high in LOAD_A, LOAD_B and LOAD_R.

Function
REQ-013 The FSM states SHALL be ENTRY_A, LOAD_A, ENTRY_B, LOAD_B, LOAD_R and SHOW.
REQ-014 LoadA, LoadB, LoadR and busy SHALL be Moore-decoded from the state register: LoadA=1 only in LOAD_A, LoadB=1 only in LOAD_B, LoadR=1 only in LOAD_R.
REQ-015 A digit d in ENTRY_A or ENTRY_B SHALL set operand to operand*10+d on the next edge, computed 12 bits wide.
REQ-016 If operand*10+d would exceed OPERAND_MAX, the digit SHALL be ignored and operand left unchanged.
REQ-017 An add or subtract key in ENTRY_A SHALL latch Cin (add=0, sub=1) and move to LOAD_A, with operand held.
REQ-018 LOAD_A SHALL last exactly 1 cycle, then go to ENTRY_B with operand cleared to 0 on the same edge.
REQ-019 An add or subtract key in ENTRY_B SHALL only replace Cin; it SHALL NOT cause a load.
REQ-020 The equals key in ENTRY_B SHALL go to LOAD_B with operand held.
REQ-021 LOAD_B SHALL go to LOAD_R, and LOAD_R SHALL go to SHOW, each after 1 cycle; LoadR SHALL assert exactly 1 cycle after LoadB.
REQ-022 disp_sel SHALL be 1 exactly when the state is SHOW.
REQ-023 The equals key in ENTRY_A SHALL be ignored.
REQ-024 A digit d in SHOW SHALL set operand to d, disp_sel to 0 and the state to ENTRY_A.
REQ-025 An add or subtract key in SHOW (chaining) SHALL load operand with result, latch Cin and go to LOAD_A.
REQ-026 The equals key in SHOW SHALL be ignored.
REQ-027 The clear key in any non-busy state SHALL, on the next edge, set operand=0, Cin=0, state=ENTRY_A, and assert clear for 1 cycle.
REQ-028 While busy=1, key_valid SHALL be ignored, including the clear key; keys are not queued.
REQ-029 Unused codes 0xD and 0xF SHALL be ignored in every state.
REQ-030 With key_valid=0, no state or register SHALL change except the automatic LOAD_A/LOAD_B/LOAD_R advances.

Reset
REQ-031 Reset SHALL give state=ENTRY_A, operand=0, Cin=0, disp_sel=0, LoadA=LoadB=LoadR=0, clear=0 and busy=0.
REQ-032 Reset asserted during LOAD_A, LOAD_B or LOAD_R SHALL abort the sequence without completing any remaining strobe.
REQ-033 The first key SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-034 The shared package calc_pkg SHALL hold the state encoding, the key-code constants and the operand width (8).
REQ-035 A sub-module dec_accum SHALL do the combinational multiply-by-ten, add and bound check, outputting next_val and accept.
REQ-036 Every output SHALL be driven from a register or from decoded state only, with no combinational path from key inputs.

Verification
REQ-037 Reset: assert reset mid-LOAD_B -> all outputs 0 in the same cycle, state ENTRY_A.
REQ-038 Add: keys 1,2,A,3,4,E with result=46 -> LoadA with operand=12, Cin=0; LoadB with operand=34; LoadR on the next cycle; then disp_sel=1.
REQ-039 Bound: keys 2,5,6 -> operand=25 (256 rejected); then key 5 -> operand=255.
REQ-040 Chain: in SHOW with result=46, key B -> operand=46, LoadA pulse, Cin=1, state ENTRY_B, operand=0.
REQ-041 Clear and ignore: in ENTRY_B with operand=7, key C -> clear pulse, operand=0, Cin=0; key_valid during LOAD_B -> no effect.
REQ-042 Operator replace and ignored equals: keys 5,A,B,3,E -> Cin=1 at LoadB and exactly one LoadA; key E in ENTRY_A -> no strobe.
